// File: rtl/vga_framebuffer_scanout_pkg.sv
// Shared VGA timing constants, widths and the scan-out enable state type.
// Defaults describe 640x480 at 60 Hz with a 25 MHz pixel clock.
package vga_framebuffer_scanout_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;

  localparam int ADDR_W = $clog2(FRAME_PIXELS);
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 10;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ARM  = 2'd1,
    S_SHOW = 2'd2
  } scan_state_t;

  // Half-open window test used for the sync pulse decode.
  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_framebuffer_scanout_timing_gen.sv
// Horizontal/vertical position counters with active-region and sync decode.
// Outputs are the undelayed counter-stage view of the raster position.
module vga_timing_gen
  import vga_framebuffer_scanout_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs,
  output logic             vs
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // Sync pulses are active-low.
  assign hs = !in_window(h_cnt, HS_BEGIN, HS_END);
  assign vs = !in_window(v_cnt, VS_BEGIN, VS_END);

endmodule

// File: rtl/vga_framebuffer_scanout.sv
// Framebuffer scan-out: raster timing, frame-aligned display enable and a
// two-stage output pipeline that lines pixels up with the delayed syncs.
module vga_framebuffer_scanout
  import vga_framebuffer_scanout_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              copy_done,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [PIX_W-1:0]  ram_rd_data,
  output logic [PIX_W-1:0]  vga_pixel,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic              frame_start,
  output logic              showing,
  output scan_state_t       state_dbg
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
  logic              active;
  logic              hs_c;
  logic              vs_c;
  logic              frame_pos;
  logic              frame_end;
  logic [ADDR_W-1:0] addr_cnt;
  scan_state_t       state;
  scan_state_t       state_nxt;
  logic              de_d1;
  logic              hs_d1;
  logic              vs_d1;
  logic              pix_en;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (active),
    .hs     (hs_c),
    .vs     (vs_c)
  );

  assign frame_pos = (h_cnt == '0) && (v_cnt == '0);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Running pixel address: avoids a row*width multiply; cleared so that it
  // reads zero exactly when the raster is back at the top-left position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_cnt <= '0;
    end else if (frame_end) begin
      addr_cnt <= '0;
    end else if (active) begin
      addr_cnt <= addr_cnt + ADDR_W'(1);
    end
  end

  // Enable FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Enable FSM: next state. Display only begins at a frame boundary so a
  // partially drawn frame is never shown.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: begin
        if (copy_done) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (!copy_done)     state_nxt = S_WAIT;
        else if (frame_pos) state_nxt = S_SHOW;
      end
      S_SHOW: begin
        if (!copy_done) state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Enable FSM: outputs.
  always_comb begin
    showing   = (state == S_SHOW);
    state_dbg = state;
  end

  // Stage 1: read address issue plus first delay of the timing signals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_rd_addr <= '0;
      de_d1       <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
    end else begin
      if (active) ram_rd_addr <= addr_cnt;
      de_d1 <= active;
      hs_d1 <= hs_c;
      vs_d1 <= vs_c;
    end
  end

  // Stage 2: timing outputs and the pixel gate, aligned with RAM read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_de      <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      pix_en      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_de      <= de_d1;
      vga_hs      <= hs_d1;
      vga_vs      <= vs_d1;
      pix_en      <= de_d1 && (state == S_SHOW);
      frame_start <= frame_pos;
    end
  end

  // The RAM's own output register is the stage-2 data flop; only the gate
  // is held here, so the pixel and its syncs leave on the same clock.
  assign vga_pixel = pix_en ? ram_rd_data : '0;

endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// Bench for vga_framebuffer_scanout using a shrunken raster so several
// frames fit in a short run; outputs are predicted from raster arithmetic.
module tb_vga_framebuffer_scanout;
  import vga_framebuffer_scanout_pkg::*;

  localparam int HA = 16, HF = 2, HSW = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int FPIX = HA * VA;
  localparam int MAXC = 8000;

  // Hand-computed figures for this raster (25 x 15 clocks, 16 x 8 visible).
  localparam int EXP_HS_PERIOD = 25;
  localparam int EXP_HS_LOW    = 4;
  localparam int EXP_VS_PERIOD = 375;
  localparam int EXP_VS_LOW    = 50;
  localparam int EXP_ADDR_MAX  = 127;
  localparam int EXP_ARM_SHOW  = 376;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              copy_done = 1'b0;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [PIX_W-1:0]  ram_rd_data = '0;
  logic [PIX_W-1:0]  vga_pixel;
  logic              vga_hs, vga_vs, vga_de, frame_start, showing;
  scan_state_t       state_dbg;

  logic [7:0] ram_mem [0:FPIX-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run_en = 1'b0;
  bit cd_hist [0:MAXC-1];
  int rs_hist [0:MAXC-1];

  bit prev_hs, prev_vs, prev_show;
  int hs_fall, vs_fall, show_rise_cyc, first_fs_cyc, max_addr;
  int pix00, pix150, pix01;

  vga_framebuffer_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .copy_done   (copy_done),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .vga_pixel   (vga_pixel),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_de      (vga_de),
    .frame_start (frame_start),
    .showing     (showing),
    .state_dbg   (state_dbg)
  );

  // Clock and synchronous-read RAM.
  always #5 clk = ~clk;

  always @(posedge clk) ram_rd_data <= ram_mem[ram_rd_addr[6:0]];

  // Raster arithmetic on an absolute cycle index p since reset release.
  function automatic bit act_at(input int p);
    int h, v;
    h = p % HT; v = (p / HT) % VT;
    return (h < HA) && (v < VA);
  endfunction

  function automatic int addr_at(input int p);
    return ((p / HT) % VT) * HA + (p % HT);
  endfunction

  function automatic bit hs_at(input int p);
    int h;
    h = p % HT;
    return !((h >= HA + HF) && (h < HA + HF + HSW));
  endfunction

  function automatic bit vs_at(input int p);
    int v;
    v = (p / HT) % VT;
    return !((v >= VA + VF) && (v < VA + VF + VSW));
  endfunction

  // Address of the most recent visible pixel at or before position p.
  function automatic int last_addr(input int p);
    int h, v;
    h = p % HT; v = (p / HT) % VT;
    if (v >= VA) return FPIX - 1;
    if (h >= HA) return v * HA + HA - 1;
    return v * HA + h;
  endfunction

  // First frame boundary strictly after cycle c.
  function automatic int first_boundary(input int c);
    return ((c + FT) / FT) * FT;
  endfunction

  // copy_done must stay high from arming until a boundary has been crossed.
  function automatic scan_state_t state_at(input int k);
    if (k == 0) return S_WAIT;
    if (!cd_hist[k-1]) return S_WAIT;
    if (k - 1 >= first_boundary(rs_hist[k-1])) return S_SHOW;
    return S_ARM;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every cycle after reset release is compared with the model.
  always @(negedge clk) begin
    if (run_en && !reset) begin
      if (cyc >= MAXC) begin
        chk("cycle_budget", cyc, MAXC - 1);
      end else begin
        automatic int k = cyc;
        automatic int exp_pix;
        cd_hist[k] = copy_done;
        rs_hist[k] = !copy_done ? -1 : ((k > 0 && cd_hist[k-1]) ? rs_hist[k-1] : k);

        exp_pix = 0;
        if (k >= 2 && act_at(k - 2) && state_at(k - 1) == S_SHOW)
          exp_pix = int'(ram_mem[addr_at(k - 2)]);

        chk("state",       int'(state_dbg),   int'(state_at(k)));
        chk("showing",     int'(showing),     int'(state_at(k) == S_SHOW));
        chk("ram_rd_addr", int'(ram_rd_addr), (k == 0) ? 0 : last_addr(k - 1));
        chk("vga_de",      int'(vga_de),      (k >= 2) ? int'(act_at(k - 2)) : 0);
        chk("vga_hs",      int'(vga_hs),      (k >= 2) ? int'(hs_at(k - 2)) : 1);
        chk("vga_vs",      int'(vga_vs),      (k >= 2) ? int'(vs_at(k - 2)) : 1);
        chk("frame_start", int'(frame_start), (k >= 1 && (k - 1) % FT == 0) ? 1 : 0);
        chk("vga_pixel",   int'(vga_pixel),   exp_pix);

        if (prev_hs && !vga_hs) begin
          if (hs_fall >= 0) chk("hs_period", k - hs_fall, EXP_HS_PERIOD);
          hs_fall = k;
        end
        if (!prev_hs && vga_hs && hs_fall >= 0) chk("hs_low", k - hs_fall, EXP_HS_LOW);
        if (prev_vs && !vga_vs) begin
          if (vs_fall >= 0) chk("vs_period", k - vs_fall, EXP_VS_PERIOD);
          vs_fall = k;
        end
        if (!prev_vs && vga_vs && vs_fall >= 0) chk("vs_low", k - vs_fall, EXP_VS_LOW);
        prev_hs = vga_hs;
        prev_vs = vga_vs;

        if (!prev_show && showing && show_rise_cyc < 0) show_rise_cyc = k;
        prev_show = showing;
        if (frame_start && first_fs_cyc < 0) first_fs_cyc = k;
        if (int'(ram_rd_addr) > max_addr) max_addr = int'(ram_rd_addr);

        if (k >= 2 && state_at(k - 1) == S_SHOW) begin
          if ((k - 2) % FT == 0)      pix00  = int'(vga_pixel);
          if ((k - 2) % FT == HA - 1) pix150 = int'(vga_pixel);
          if ((k - 2) % FT == HT)     pix01  = int'(vga_pixel);
        end
        cyc++;
      end
    end
  end

  // Called just after a rising edge; pulses reset and checks reset values.
  task automatic apply_reset(input int hold);
    run_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_ram_rd_addr", int'(ram_rd_addr), 0);
    chk("rst_vga_pixel",   int'(vga_pixel),   0);
    chk("rst_vga_de",      int'(vga_de),      0);
    chk("rst_vga_hs",      int'(vga_hs),      1);
    chk("rst_vga_vs",      int'(vga_vs),      1);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_showing",     int'(showing),     0);
    chk("rst_state",       int'(state_dbg),   int'(S_WAIT));
    repeat (hold) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_show = 1'b0;
    hs_fall = -1; vs_fall = -1; show_rise_cyc = -1; first_fs_cyc = -1;
    max_addr = 0; pix00 = -1; pix150 = -1; pix01 = -1;
    run_en = 1'b1;
  endtask

  // Returns just after the rising edge that starts raster position (h,v).
  task automatic wait_pos(input int h, input int v);
    int tgt, n;
    tgt = v * HT + h;
    n = 0;
    @(posedge clk); #1;
    while ((cyc % FT) != tgt && n < FT + 2) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_pos", cyc % FT, tgt);
  endtask

  initial begin
    for (int i = 0; i < FPIX; i++) ram_mem[i] = 8'(i);

    // Blank display with copy_done low: cadence only, pixels stay zero.
    @(posedge clk); #1;
    apply_reset(3);
    repeat (2 * FT + 10) @(posedge clk);

    // copy_done high from reset: display starts at the second boundary.
    #1;
    copy_done = 1'b1;
    apply_reset(2);
    repeat (2 * FT + 10) @(posedge clk);
    chk("addr_max",   max_addr, EXP_ADDR_MAX);
    chk("first_show", show_rise_cyc, EXP_ARM_SHOW);
    chk("pix_0_0",    pix00,  8'h00);
    chk("pix_15_0",   pix150, 8'h0F);
    chk("pix_0_1",    pix01,  8'h10);

    // Drop copy_done mid-frame: blanking begins two clocks later.
    wait_pos(8, 4);
    copy_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("drop_pix_t1", int'(vga_pixel), 8'h47);
    @(negedge clk);
    chk("drop_pix_t2", int'(vga_pixel), 8'h00);

    // Raise copy_done exactly at the frame boundary.
    wait_pos(0, 0);
    copy_done = 1'b1;
    begin
      automatic int rise = cyc;
      show_rise_cyc = -1;
      repeat (FT + 5) @(posedge clk);
      chk("arm_to_show", show_rise_cyc - rise, EXP_ARM_SHOW);
    end

    // Reset pulse in the middle of a displayed frame.
    wait_pos(12, 5);
    apply_reset(2);
    repeat (4) @(posedge clk);
    chk("fs_after_reset", first_fs_cyc, 1);
    repeat (FT) @(posedge clk);

    // Random RAM contents and random copy_done run lengths.
    #1;
    run_en = 1'b0;
    for (int i = 0; i < FPIX; i++) ram_mem[i] = 8'($urandom_range(0, 255));
    copy_done = 1'($urandom_range(0, 1));
    apply_reset(2);
    for (int s = 0; s < 8; s++) begin
      repeat ($urandom_range(20, 800)) @(posedge clk);
      #1;
      copy_done = !copy_done;
    end
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
